// File: rtl/canny_pkg.sv
// Shared constants and FSM encoding for the adaptive Canny threshold controller.
package canny_pkg;

    localparam int MAG_W = 10;

    localparam logic [1:0] CFG_MODE = 2'd0;
    localparam logic [1:0] CFG_LOW  = 2'd1;
    localparam logic [1:0] CFG_HIGH = 2'd2;
    localparam logic [1:0] CFG_GAIN = 2'd3;

    localparam logic [MAG_W-1:0] THR_LOW_DEF   = 10'd50;
    localparam logic [MAG_W-1:0] THR_HIGH_DEF  = 10'd100;
    localparam logic [MAG_W-1:0] THR_FLOOR_DEF = 10'd20;
    localparam logic [5:0]       GAIN_DEF      = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SNAP,
        ST_DIV,
        ST_SCALE
    } state_t;

endpackage

// File: rtl/canny_serial_div.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Latency: ACC_W cycles after start; done is high during the final step, quotient valid the cycle after.
// Backpressure: none; start while running restarts the divide.
module canny_serial_div #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 21
) (
    input  logic             clk,
    input  logic             rst_s,
    input  logic             start,
    input  logic [ACC_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [ACC_W-1:0] quotient
);

    localparam int BW = $clog2(ACC_W);

    logic [CNT_W:0]   rem_q;
    logic [CNT_W-1:0] dvs_q;
    logic [BW-1:0]    bit_q;
    logic             run_q;
    logic [CNT_W:0]   rem_sh;
    logic [CNT_W:0]   diff;
    logic             ge;

    // The dividend is shifted out of the quotient register as quotient bits shift in.
    assign rem_sh = {rem_q[CNT_W-1:0], quotient[ACC_W-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign ge     = (rem_sh >= {1'b0, dvs_q});
    assign done   = run_q && (bit_q == BW'(ACC_W - 1));

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            rem_q    <= '0;
            dvs_q    <= '0;
            bit_q    <= '0;
            run_q    <= 1'b0;
            quotient <= '0;
        end else if (start) begin
            rem_q    <= '0;
            dvs_q    <= divisor;
            bit_q    <= '0;
            run_q    <= 1'b1;
            quotient <= dividend;
        end else if (run_q) begin
            rem_q    <= ge ? diff : rem_sh;
            quotient <= {quotient[ACC_W-2:0], ge};
            bit_q    <= bit_q + BW'(1);
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/canny_threshold_ctrl.sv
// Per-frame adaptive Canny double-threshold controller; optional stats outputs under CANNY_THR_STATS_EN.
// Latency: new thresholds ready 35 cycles after frame end, committed at next frame start with a thr_valid pulse.
// Backpressure: none; a frame ending while a computation is in flight is discarded.
module canny_threshold_ctrl
    import canny_pkg::*;
#(
    parameter logic [MAG_W-1:0] THR_LOW_RST  = THR_LOW_DEF,
    parameter logic [MAG_W-1:0] THR_HIGH_RST = THR_HIGH_DEF,
    parameter logic [MAG_W-1:0] THR_FLOOR    = THR_FLOOR_DEF,
    parameter logic [5:0]       GAIN_RST     = GAIN_DEF,
    parameter int               ACC_W        = 32,
    parameter int               CNT_W        = 21
) (
    input  logic             clk,
    input  logic             rst_s,
    input  logic             grad_vs,
    input  logic             grad_de,
    input  logic [MAG_W-1:0] grad_mag,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [15:0]      cfg_wdata,
    output logic [15:0]      cfg_rdata,
    output logic [MAG_W-1:0] thr_low,
    output logic [MAG_W-1:0] thr_high,
    output logic             thr_valid,
    output logic             busy
`ifdef CANNY_THR_STATS_EN
    ,
    output logic [MAG_W-1:0] stat_mean,
    output logic [CNT_W-1:0] stat_pixels
`endif
);

    state_t           state_q, state_d;
    logic             vs_r, vs_rise, vs_fall;
    logic             acc_en, acc_clr, div_start, div_done;
    logic [ACC_W-1:0] acc_sum, quotient;
    logic [CNT_W-1:0] acc_cnt;
    logic [ACC_W:0]   sum_inc;
    logic             mode_q;
    logic [MAG_W-1:0] static_low, static_high, pend_low, pend_high;
    logic [5:0]       gain_q;
    logic [MAG_W-1:0] mean, h_clamp;
    logic [15:0]      prod;
    logic [11:0]      h_raw;

    assign vs_rise = grad_vs & ~vs_r;
    assign vs_fall = ~grad_vs & vs_r;
    assign acc_en  = grad_vs & grad_de;
    assign acc_clr = (state_q == ST_SNAP) || (vs_fall && (state_q != ST_IDLE));
    assign sum_inc = {1'b0, acc_sum} + {{(ACC_W + 1 - MAG_W){1'b0}}, grad_mag};
    assign busy    = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            vs_r    <= 1'b0;
            acc_sum <= '0;
            acc_cnt <= '0;
        end else begin
            vs_r <= grad_vs;
            // A pixel arriving in the clearing cycle starts the next frame's totals.
            if (acc_clr) begin
                acc_sum <= acc_en ? {{(ACC_W - MAG_W){1'b0}}, grad_mag} : '0;
                acc_cnt <= acc_en ? CNT_W'(1) : '0;
            end else if (acc_en) begin
                acc_sum <= sum_inc[ACC_W] ? '1 : sum_inc[ACC_W-1:0];
                if (!(&acc_cnt)) begin
                    acc_cnt <= acc_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE:  if (vs_fall) state_d = ST_SNAP;
            ST_SNAP: begin
                if (acc_cnt != '0) begin
                    div_start = 1'b1;
                    state_d   = ST_DIV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIV:   if (div_done) state_d = ST_SCALE;
            ST_SCALE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    canny_serial_div #(
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_s    (rst_s),
        .start    (div_start),
        .dividend (acc_sum),
        .divisor  (acc_cnt),
        .done     (div_done),
        .quotient (quotient)
    );

    always_comb begin
        mean  = (|quotient[ACC_W-1:MAG_W]) ? '1 : quotient[MAG_W-1:0];
        prod  = {6'd0, mean} * {10'd0, gain_q};
        h_raw = prod[15:4];
        if (h_raw > 12'd1023) begin
            h_clamp = '1;
        end else if (h_raw < {2'b00, THR_FLOOR}) begin
            h_clamp = THR_FLOOR;
        end else begin
            h_clamp = h_raw[MAG_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            pend_low  <= THR_LOW_RST;
            pend_high <= THR_HIGH_RST;
            thr_low   <= THR_LOW_RST;
            thr_high  <= THR_HIGH_RST;
            thr_valid <= 1'b0;
        end else begin
            if (state_q == ST_SCALE) begin
                pend_high <= h_clamp;
                pend_low  <= h_clamp >> 1;
            end
            thr_valid <= vs_rise;
            if (vs_rise) begin
                if (mode_q) begin
                    thr_low  <= pend_low;
                    thr_high <= pend_high;
                end else begin
                    thr_low  <= (static_low < static_high) ? static_low : static_high;
                    thr_high <= (static_low < static_high) ? static_high : static_low;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            mode_q      <= 1'b0;
            static_low  <= THR_LOW_RST;
            static_high <= THR_HIGH_RST;
            gain_q      <= GAIN_RST;
            cfg_rdata   <= '0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    CFG_MODE: mode_q      <= cfg_wdata[0];
                    CFG_LOW:  static_low  <= cfg_wdata[MAG_W-1:0];
                    CFG_HIGH: static_high <= cfg_wdata[MAG_W-1:0];
                    default:  gain_q      <= cfg_wdata[5:0];
                endcase
            end
            case (cfg_addr)
                CFG_MODE: cfg_rdata <= {15'd0, mode_q};
                CFG_LOW:  cfg_rdata <= {6'd0, static_low};
                CFG_HIGH: cfg_rdata <= {6'd0, static_high};
                default:  cfg_rdata <= {10'd0, gain_q};
            endcase
        end
    end

`ifdef CANNY_THR_STATS_EN
    logic [CNT_W-1:0] snap_cnt;

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            snap_cnt    <= '0;
            stat_mean   <= '0;
            stat_pixels <= '0;
        end else begin
            if (div_start) begin
                snap_cnt <= acc_cnt;
            end
            if (state_q == ST_SCALE) begin
                stat_mean   <= mean;
                stat_pixels <= snap_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_canny_threshold_ctrl.sv
// Directed and randomized frame bench for canny_threshold_ctrl with a frame-level reference model.
module tb_canny_threshold_ctrl;

    logic        clk = 1'b0;
    logic        rst_s = 1'b0;
    logic        grad_vs = 1'b0;
    logic        grad_de = 1'b0;
    logic [9:0]  grad_mag = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic [15:0] cfg_rdata;
    logic [9:0]  thr_low, thr_high;
    logic        thr_valid, busy;
`ifdef CANNY_THR_STATS_EN
    logic [9:0]  stat_mean;
    logic [20:0] stat_pixels;
`endif

    canny_threshold_ctrl dut (
        .clk       (clk),
        .rst_s     (rst_s),
        .grad_vs   (grad_vs),
        .grad_de   (grad_de),
        .grad_mag  (grad_mag),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .thr_low   (thr_low),
        .thr_high  (thr_high),
        .thr_valid (thr_valid),
        .busy      (busy)
`ifdef CANNY_THR_STATS_EN
        ,
        .stat_mean   (stat_mean),
        .stat_pixels (stat_pixels)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vld_pulses = 0;
    int exp_pulses = 0;

    // Reference model: register shadows, pending and committed thresholds, frame totals.
    int     m_mode, m_sl, m_sh, m_gain;
    int     m_pl, m_ph, exp_lo, exp_hi;
    int     def_pl, def_ph;
    bit     deferred;
    longint f_sum;
    int     f_cnt;

    always @(posedge clk) begin
        #1;
        if (thr_valid === 1'b1) vld_pulses++;
    end

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_sl = 50; m_sh = 100; m_gain = 32;
        m_pl = 50; m_ph = 100; exp_lo = 50; exp_hi = 100;
        deferred = 0; f_sum = 0; f_cnt = 0;
    endtask

    task automatic cfg_write(input int a, input int d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 2'(a); cfg_wdata = 16'(d);
        @(negedge clk);
        cfg_we = 1'b0;
        case (a)
            0: m_mode = d & 1;
            1: m_sl = d & 1023;
            2: m_sh = d & 1023;
            default: m_gain = d & 63;
        endcase
    endtask

    task automatic cfg_read(input int a, input string tag);
        int expv;
        @(negedge clk);
        cfg_addr = 2'(a);
        @(negedge clk);
        case (a)
            0: expv = m_mode;
            1: expv = m_sl;
            2: expv = m_sh;
            default: expv = m_gain;
        endcase
        check(tag, int'(cfg_rdata), expv);
    endtask

    task automatic start_frame(input string tag);
        @(negedge clk);
        check({tag, "_hold_low"}, int'(thr_low), exp_lo);
        check({tag, "_hold_high"}, int'(thr_high), exp_hi);
        grad_vs = 1'b1; grad_de = 1'b0;
        if (m_mode != 0) begin
            exp_lo = m_pl; exp_hi = m_ph;
        end else begin
            exp_lo = (m_sl < m_sh) ? m_sl : m_sh;
            exp_hi = (m_sl < m_sh) ? m_sh : m_sl;
        end
        exp_pulses++;
        @(posedge clk);
        #1;
        check({tag, "_valid"}, int'(thr_valid), 1);
        check({tag, "_low"}, int'(thr_low), exp_lo);
        check({tag, "_high"}, int'(thr_high), exp_hi);
        if (deferred) begin
            m_pl = def_pl; m_ph = def_ph; deferred = 0;
        end
    endtask

    task automatic pixels(input int n, input int lo, input int hi, input int de_pct);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            grad_de = ($urandom_range(99) < de_pct);
            grad_mag = 10'($urandom_range(hi, lo));
            if (grad_de) begin
                f_sum += longint'(grad_mag);
                f_cnt++;
            end
        end
        @(negedge clk);
        grad_de = 1'b0;
    endtask

    task automatic end_frame(input int gap, input string tag);
        int mean, h;
        @(negedge clk);
        grad_vs = 1'b0; grad_de = 1'b0;
        def_pl = m_pl; def_ph = m_ph;
        if (f_cnt > 0) begin
            mean = int'(f_sum / longint'(f_cnt));
            if (mean > 1023) mean = 1023;
            h = (mean * m_gain) / 16;
            if (h > 1023) h = 1023;
            if (h < 20) h = 20;
            def_ph = h; def_pl = h / 2;
        end
        f_sum = 0; f_cnt = 0;
        @(negedge clk);
        check({tag, "_busy_rise"}, int'(busy), 1);
        repeat (gap - 1) @(negedge clk);
        if (gap >= 40) begin
            check({tag, "_busy_done"}, int'(busy), 0);
            m_pl = def_pl; m_ph = def_ph;
        end else begin
            deferred = 1;
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_low", int'(thr_low), 50);
        check("rst_high", int'(thr_high), 100);
        check("rst_valid", int'(thr_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rdata", int'(cfg_rdata), 0);
        rst_s = 1'b1;
        cfg_read(0, "rd_mode");
        cfg_read(1, "rd_low");
        cfg_read(2, "rd_high");
        cfg_read(3, "rd_gain");
        cfg_write(0, 1);

        // Frame without pixels: pending stays at reset values.
        start_frame("t4a");
        pixels(16, 0, 1023, 0);
        end_frame(45, "t4");
        // 4x4 frame of 40, gain 2.0.
        start_frame("t4b");
        pixels(16, 40, 40, 100);
        end_frame(45, "t1");
        cfg_write(3, 63);
        start_frame("t1");
        check("t1_high_abs", int'(thr_high), 80);
        pixels(16, 1000, 1000, 100);
        end_frame(45, "t2");
        cfg_write(3, 32);
        start_frame("t2");
        check("t2_high_abs", int'(thr_high), 1023);
        pixels(16, 2, 2, 100);
        end_frame(45, "t3");
        start_frame("t3");
        check("t3_high_abs", int'(thr_high), 20);
        // Static mode with swapped limits, written mid-frame.
        pixels(8, 0, 300, 80);
        cfg_write(0, 0);
        cfg_write(1, 120);
        cfg_write(2, 60);
        pixels(8, 0, 300, 80);
        end_frame(45, "t5");
        start_frame("t5");
        check("t5_low_abs", int'(thr_low), 60);
        cfg_read(1, "rd_low2");
        cfg_write(0, 1);
        pixels(20, 100, 700, 70);
        // Next frame starts while the divide is still running.
        end_frame(3, "ovl");
        start_frame("ovl");
        pixels(45, 0, 1023, 60);
        end_frame(45, "ovl2");

        for (int f = 0; f < 6; f++) begin
            cfg_write(3, int'($urandom_range(63, 1)));
            cfg_write(0, int'($urandom_range(3) != 0));
            cfg_write(1, int'($urandom_range(1023)));
            cfg_write(2, int'($urandom_range(1023)));
            start_frame("rnd");
            pixels(int'($urandom_range(40, 1)), int'($urandom_range(200)),
                   int'($urandom_range(1023, 200)), int'($urandom_range(100, 30)));
            end_frame(45, "rnd");
        end

        // Reset while the divider is running.
        cfg_write(0, 1);
        start_frame("pre_rst");
        pixels(12, 300, 900, 100);
        end_frame(10, "pre_rst");
        @(negedge clk);
        rst_s = 1'b0;
        #1;
        model_reset();
        check("mid_rst_low", int'(thr_low), 50);
        check("mid_rst_high", int'(thr_high), 100);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_rdata", int'(cfg_rdata), 0);
        @(negedge clk);
        rst_s = 1'b1;
        cfg_write(0, 1);
        start_frame("t6a");
        pixels(16, 40, 40, 100);
        end_frame(45, "t6");
        start_frame("t6");
        check("t6_high_abs", int'(thr_high), 80);
        pixels(4, 0, 10, 100);
        end_frame(45, "fin");

        repeat (3) @(negedge clk);
        check("valid_pulses", vld_pulses, exp_pulses);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
